// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
//   Issue bus between the fetch/assemble stage and execute/decode.
//   The fetch stage is the master: it drives a fully assembled instruction
//   plus instr_valid, and execute answers with instr_ready.
//
//   instr_valid   master->slave  assembled instruction available
//   instr_ready   slave->master  execute accepts the instruction
//   instr_opcode  master->slave  opcode byte
//   instr_op1     master->slave  first operand byte (0 if absent)
//   instr_op2     master->slave  second operand byte (0 if absent)
//   instr_len     master->slave  instruction length in bytes (1..3)
//   instr_pc      master->slave  address of the opcode byte
// ----------------------------------------------------------------------------
interface instruction_fetch_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr_opcode;
   logic [7:0] instr_op1;
   logic [7:0] instr_op2;
   logic [1:0] instr_len;
   logic [7:0] instr_pc;

   modport master (
      output instr_valid,
      input  instr_ready,
      output instr_opcode,
      output instr_op1,
      output instr_op2,
      output instr_len,
      output instr_pc
   );

   modport slave (
      input  instr_valid,
      output instr_ready,
      input  instr_opcode,
      input  instr_op1,
      input  instr_op2,
      input  instr_len,
      input  instr_pc
   );
endinterface

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch/assemble stage between an 8-bit program memory and execute.
//   Reads one byte per cycle from the memory's combinational output,
//   assembles 1..3 byte instructions, resolves JMP locally without issuing
//   it, and stops on an illegal opcode (or skips it, see ILLEGAL_HALT).
//
//   Parameters
//     RESET_PC      PC loaded on reset
//     ILLEGAL_HALT  1: halt on unknown opcode, 0: skip it as a 1-byte no-op
//
//   Ports
//     clk             system clock, rising edge
//     rst_n           asynchronous active-low reset
//     pm_addr         program-memory byte address (always equals pc)
//     pm_data         program-memory byte at pm_addr, same cycle
//     redirect_valid  execute-side PC override request
//     redirect_addr   new PC when redirect_valid=1
//     instr           issue bus (master side)
//     halted          fetch stopped on an illegal opcode
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_OP    | fetch opcode byte, capture its address, clear operands
//   S_B1    | fetch first operand byte (JMP target for JMP)
//   S_B2    | fetch second operand byte
//   S_ISSUE | present instruction, hold until instr_ready
//   S_HALT  | illegal opcode seen; wait for redirect or reset
// ----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [7:0] RESET_PC     = 8'h00,
   parameter logic       ILLEGAL_HALT = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic [7:0]                  pm_addr,
   input  logic [7:0]                  pm_data,
   input  logic                        redirect_valid,
   input  logic [7:0]                  redirect_addr,
   instruction_fetch_if.master         instr,
   output logic                        halted
);

   typedef enum logic [2:0] {
      S_OP    = 3'd0,
      S_B1    = 3'd1,
      S_B2    = 3'd2,
      S_ISSUE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [7:0] OP_JMP = 8'h07;

   // Length decode; 0 marks an illegal opcode.
   function automatic logic [1:0] op_len(input logic [7:0] op);
      logic [1:0] len;
      case (op)
         8'h00:   len = 2'd3;
         8'h01:   len = 2'd2;
         8'h03:   len = 2'd2;
         8'h06:   len = 2'd3;
         8'h07:   len = 2'd2;
         8'h12:   len = 2'd1;
         default: len = 2'd0;
      endcase
      return len;
   endfunction

   state_t     state;
   state_t     state_nxt;
   logic [7:0] pc;
   logic [7:0] pc_nxt;
   logic [7:0] pc_inc;
   logic [1:0] fetch_len;

   logic [7:0] opcode_q;
   logic [7:0] op1_q;
   logic [7:0] op2_q;
   logic [1:0] len_q;
   logic [7:0] ipc_q;

   assign pc_inc    = pc + 8'd1;
   assign fetch_len = op_len(pm_data);

   // ---------------------------------------------------------------------
   // State and PC register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_OP;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and next-PC
   // Redirect overrides everything, including a handshake in S_ISSUE and a
   // JMP target load in S_B1.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (redirect_valid) begin
         state_nxt = S_OP;
         pc_nxt    = redirect_addr;
      end else begin
         case (state)
            S_OP: begin
               pc_nxt = pc_inc;
               if (fetch_len == 2'd0)
                  state_nxt = ILLEGAL_HALT ? S_HALT : S_OP;
               else if (fetch_len == 2'd1)
                  state_nxt = S_ISSUE;
               else
                  state_nxt = S_B1;
            end
            S_B1: begin
               if (opcode_q == OP_JMP) begin
                  pc_nxt    = pm_data;
                  state_nxt = S_OP;
               end else begin
                  pc_nxt    = pc_inc;
                  state_nxt = (len_q == 2'd3) ? S_B2 : S_ISSUE;
               end
            end
            S_B2: begin
               pc_nxt    = pc_inc;
               state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
               if (instr.instr_ready)
                  state_nxt = S_OP;
            end
            S_HALT: begin
               state_nxt = S_HALT;
            end
            default: begin
               state_nxt = S_OP;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Instruction assembly registers. Operands are cleared when a new opcode
   // is fetched so absent operands read as zero. A redirect suppresses any
   // capture; the discarded fields are never presented as valid.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q <= 8'h00;
         op1_q    <= 8'h00;
         op2_q    <= 8'h00;
         len_q    <= 2'd1;
         ipc_q    <= 8'h00;
      end else if (!redirect_valid) begin
         case (state)
            S_OP: begin
               opcode_q <= pm_data;
               ipc_q    <= pc;
               op1_q    <= 8'h00;
               op2_q    <= 8'h00;
               len_q    <= (fetch_len == 2'd0) ? 2'd1 : fetch_len;
            end
            S_B1: begin
               op1_q <= pm_data;
            end
            S_B2: begin
               op2_q <= pm_data;
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   always_comb begin
      pm_addr            = pc;
      halted             = (state == S_HALT);
      instr.instr_valid  = (state == S_ISSUE);
      instr.instr_opcode = opcode_q;
      instr.instr_op1    = op1_q;
      instr.instr_op2    = op2_q;
      instr.instr_len    = len_q;
      instr.instr_pc     = ipc_q;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] op1;
      logic [7:0] op2;
      logic [1:0] len;
      logic [7:0] pc;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_w_n;
   logic [7:0] mem_a [256];
   logic [7:0] mem_w [256];

   logic [7:0] pm_addr_a, pm_data_a, redirect_addr_a;
   logic       redirect_valid_a, halted_a;
   logic [7:0] pm_addr_w, pm_data_w, redirect_addr_w;
   logic       redirect_valid_w, halted_w;

   instruction_fetch_if bus_a ();
   instruction_fetch_if bus_w ();

   item_t q_a [$];
   item_t q_w [$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   assign pm_data_a = mem_a[pm_addr_a];
   assign pm_data_w = mem_w[pm_addr_w];

   instruction_fetch #(.RESET_PC(8'h00), .ILLEGAL_HALT(1'b1)) dut_a (
      .clk            (clk),
      .rst_n          (rst_n),
      .pm_addr        (pm_addr_a),
      .pm_data        (pm_data_a),
      .redirect_valid (redirect_valid_a),
      .redirect_addr  (redirect_addr_a),
      .instr          (bus_a),
      .halted         (halted_a)
   );

   instruction_fetch #(.RESET_PC(8'hFF), .ILLEGAL_HALT(1'b1)) dut_w (
      .clk            (clk),
      .rst_n          (rst_w_n),
      .pm_addr        (pm_addr_w),
      .pm_data        (pm_data_w),
      .redirect_valid (redirect_valid_w),
      .redirect_addr  (redirect_addr_w),
      .instr          (bus_w),
      .halted         (halted_w)
   );

   function automatic item_t mk(input logic [7:0] op, input logic [7:0] op1,
                                input logic [7:0] op2, input logic [1:0] len,
                                input logic [7:0] pc);
      item_t it;
      it.op  = op;
      it.op1 = op1;
      it.op2 = op2;
      it.len = len;
      it.pc  = pc;
      return it;
   endfunction

   function automatic item_t bus_a_item();
      return mk(bus_a.instr_opcode, bus_a.instr_op1, bus_a.instr_op2,
                bus_a.instr_len, bus_a.instr_pc);
   endfunction

   function automatic item_t bus_w_item();
      return mk(bus_w.instr_opcode, bus_w.instr_op1, bus_w.instr_op2,
                bus_w.instr_len, bus_w.instr_pc);
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_prog();
      q_a.push_back(mk(8'h03, 8'h14, 8'h00, 2'd2, 8'h03));
      q_a.push_back(mk(8'h06, 8'h07, 8'h02, 2'd3, 8'h05));
      q_a.push_back(mk(8'h01, 8'h02, 8'h00, 2'd2, 8'h08));
      q_a.push_back(mk(8'h12, 8'h00, 8'h00, 2'd1, 8'h0A));
      q_a.push_back(mk(8'h00, 8'h03, 8'h02, 2'd3, 8'h0B));
   endtask

   task automatic redirect_a(input logic [7:0] addr);
      redirect_addr_a  = addr;
      redirect_valid_a = 1'b1;
      @(posedge clk);
      #1;
      redirect_valid_a = 1'b0;
   endtask

   task automatic wait_halt_a(input string name);
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (halted_a) break;
      end
      check({name, "_halted"}, 64'(halted_a), 64'd1);
      check({name, "_halt_pm_addr"}, 64'(pm_addr_a), 64'h0F);
      check({name, "_queue_drained"}, 64'(q_a.size()), 64'd0);
   endtask

   task automatic check_reset_a(input string name);
      check({name, "_fields"}, 64'(bus_a_item()), 64'(mk(8'h00, 8'h00, 8'h00, 2'd1, 8'h00)));
      check({name, "_valid"}, 64'(bus_a.instr_valid), 64'd0);
      check({name, "_halted"}, 64'(halted_a), 64'd0);
      check({name, "_pm_addr"}, 64'(pm_addr_a), 64'h00);
   endtask

   initial begin
      rst_n            = 1'b0;
      rst_w_n          = 1'b0;
      redirect_valid_a = 1'b0;
      redirect_addr_a  = 8'h00;
      redirect_valid_w = 1'b0;
      redirect_addr_w  = 8'h00;
      bus_a.instr_ready = 1'b1;
      bus_w.instr_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'hFF;
         mem_w[i] = 8'hFF;
      end
      {mem_a[0], mem_a[1], mem_a[2], mem_a[3], mem_a[4]}    = {8'h07, 8'h03, 8'h01, 8'h03, 8'h14};
      {mem_a[5], mem_a[6], mem_a[7], mem_a[8], mem_a[9]}    = {8'h06, 8'h07, 8'h02, 8'h01, 8'h02};
      {mem_a[10], mem_a[11], mem_a[12], mem_a[13], mem_a[14]} = {8'h12, 8'h00, 8'h03, 8'h02, 8'hFF};
      mem_w[8'hFF] = 8'h01;
      mem_w[8'h00] = 8'h04;
      mem_w[8'h01] = 8'h12;

      fork
         begin : monitor
            forever begin
               @(negedge clk);
               if (rst_n && bus_a.instr_valid && bus_a.instr_ready && !redirect_valid_a) begin
                  if (q_a.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL issue_a: unexpected issue got %h", bus_a_item());
                  end else begin
                     check("issue_a", 64'(bus_a_item()), 64'(q_a.pop_front()));
                  end
               end
               if (rst_w_n && bus_w.instr_valid && bus_w.instr_ready) begin
                  if (q_w.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL issue_w: unexpected issue got %h", bus_w_item());
                  end else begin
                     check("issue_w", 64'(bus_w_item()), 64'(q_w.pop_front()));
                  end
               end
            end
         end
         begin : stimulus
            // Reset state
            #12;
            check_reset_a("reset");
            check("reset_w_pm_addr", 64'(pm_addr_w), 64'hFF);

            // Full program, ready tied high; JMP at 0 skips address 2
            push_prog();
            rst_n = 1'b1;
            wait_halt_a("prog");
            repeat (3) @(posedge clk);
            #1;
            check("halt_frozen_pm_addr", 64'(pm_addr_a), 64'h0F);
            check("halt_frozen_valid", 64'(bus_a.instr_valid), 64'd0);

            // Halt recovery by redirect, with backpressure on the first issue
            bus_a.instr_ready = 1'b0;
            push_prog();
            redirect_a(8'h00);
            check("recover_halted", 64'(halted_a), 64'd0);
            check("recover_pm_addr", 64'(pm_addr_a), 64'h00);
            for (int i = 0; i < 20; i++) begin
               if (bus_a.instr_valid) break;
               @(posedge clk);
               #1;
            end
            for (int i = 0; i < 5; i++) begin
               check("bp_valid", 64'(bus_a.instr_valid), 64'd1);
               check("bp_fields", 64'(bus_a_item()), 64'(mk(8'h03, 8'h14, 8'h00, 2'd2, 8'h03)));
               check("bp_pm_addr", 64'(pm_addr_a), 64'h05);
               @(posedge clk);
               #1;
            end
            bus_a.instr_ready = 1'b1;
            wait_halt_a("bp");

            // Redirect colliding with the handshake of the pc 8 instruction
            q_a.push_back(mk(8'h03, 8'h14, 8'h00, 2'd2, 8'h03));
            q_a.push_back(mk(8'h06, 8'h07, 8'h02, 2'd3, 8'h05));
            q_a.push_back(mk(8'h12, 8'h00, 8'h00, 2'd1, 8'h0A));
            q_a.push_back(mk(8'h00, 8'h03, 8'h02, 2'd3, 8'h0B));
            redirect_a(8'h00);
            for (int i = 0; i < 40; i++) begin
               @(posedge clk);
               #1;
               if (bus_a.instr_valid && bus_a.instr_pc == 8'h08) break;
            end
            redirect_a(8'h0A);
            check("collide_valid", 64'(bus_a.instr_valid), 64'd0);
            check("collide_pm_addr", 64'(pm_addr_a), 64'h0A);
            wait_halt_a("collide");

            // Asynchronous reset in the middle of S_B2
            redirect_a(8'h05);
            @(posedge clk);
            @(posedge clk);
            #3;
            check("mid_b2_fields", 64'(bus_a_item()), 64'(mk(8'h06, 8'h07, 8'h00, 2'd3, 8'h05)));
            check("mid_b2_pm_addr", 64'(pm_addr_a), 64'h07);
            rst_n = 1'b0;
            #1;
            check_reset_a("async_rst");
            @(posedge clk);
            #2;
            push_prog();
            rst_n = 1'b1;
            #1;
            check("rst_release_pm_addr", 64'(pm_addr_a), 64'h00);
            wait_halt_a("after_rst");

            // PC wrap from 0xFF to 0x00
            q_w.push_back(mk(8'h01, 8'h04, 8'h00, 2'd2, 8'hFF));
            q_w.push_back(mk(8'h12, 8'h00, 8'h00, 2'd1, 8'h01));
            rst_w_n = 1'b1;
            for (int i = 0; i < 30; i++) begin
               @(posedge clk);
               #1;
               if (halted_w) break;
            end
            check("wrap_halted", 64'(halted_w), 64'd1);
            check("wrap_pm_addr", 64'(pm_addr_w), 64'h03);
            check("wrap_queue_drained", 64'(q_w.size()), 64'd0);
         end
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
